jacobi_feeder: RTL and testbench
================================

# jacobi_feeder

Host-side initiator for the `jacobi_iter` solver. Buffers one matrix A and one vector B written by the host, then runs the solver's whole protocol: solver reset, `go`, paced `load_B` and `load_A` pulses, and capture of the streamed X result. The host gets a single start/done handshake, a random-access result port and pass/fail/timeout status. The block sits between the host register bus and one `jacobi_iter` instance.

## Interface
- `W`, 27: data width, signed fixed point with 8 fraction bits (Q18.8).
- `MAX_N`, 15: largest system size. Buffer depths are MAX_N for B and MAX_N*MAX_N for A.
- `GAP`, 2: low cycles after each 1-cycle load pulse; minimum legal value is 1.
- `TIMEOUT`, 65535: cycles to wait for solver `drdy` before aborting.

Ports:
- `clk` in 1: clock.
- `rst` in 1: one clock; reset is synchronous and active-low.
- `cfg_we` in 1: host buffer write strobe.
- `cfg_sel` in 1: 0 = B buffer, 1 = A buffer (row-major, index i*N+j).
- `cfg_addr` in 8: buffer index.
- `cfg_data` in W: write data.
- `n_in` in 8: system size N, sampled on accepted `start`.
- `start` in 1: single-cycle run request.
- `busy` out 1: run in progress.
- `done` out 1: 1-cycle pulse at end of run.
- `fail_flag` out 1: sticky until next accepted start.
- `timeout_flag` out 1: sticky until next accepted start.
- `res_addr` in 8: result index.
- `res_data` out W: X[res_addr], registered, 1-cycle latency.
- `sol_rst` out 1: active-high reset to solver.
- `go` out 1: solver go.
- `load_B` out 1: solver B load strobe.
- `load_A` out 1: solver A load strobe.
- `B_next` out W: B value to solver.
- `A_next` out W: A value to solver.
- `sol_drdy` in 1: solver data ready.
- `sol_dout` in W: solver result stream.
- `sol_fail` in 1: solver fail flag.

## Operation
- States: IDLE, SRST, GO, LDB, GAPB, LDA, WAIT, CAP, FIN.
- **IDLE:**
  - `cfg_we` writes the selected buffer. Out-of-range address writes are dropped.
  - Accepted `start`: if `n_in`==0 or `n_in`>MAX_N, go to FIN with `fail_flag`=1 and no solver activity. Otherwise latch N, clear both flags and go to SRST.
- **SRST:** `sol_rst`=1 for 2 cycles, then 1 cycle low, then go to GO.
- **GO:** `go`=1 for 1 cycle, then low for GAP cycles, then go to LDB.
- **LDB:** N pulses. For k=0..N-1:
  - `B_next`=B[k] is driven from the pulse's high cycle through its last low cycle.
  - `load_B`=1 for 1 cycle, then 0 for GAP cycles.
- **GAPB:** 2 idle cycles so the solver can reach its A-load state.
- **LDA:** N*N pulses, same pacing as LDB, driving `A_next`=A[k] for k=0..N*N-1 in row-major order.
- **WAIT:** timer counts cycles.
  - On `sol_drdy`=1 with `sol_fail`=1: set `fail_flag`, go to FIN.
  - On `sol_drdy`=1 with `sol_fail`=0: store `sol_dout` as X[0] in that same cycle, go to CAP.
  - If the timer reaches TIMEOUT: set `timeout_flag`, go to FIN.
- **CAP:** store `sol_dout` into X[1]..X[N-1] on the next N-1 consecutive cycles, then go to FIN.
- **FIN:** `done`=1 for 1 cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `start` while `busy`: ignored. `cfg_we` while `busy`: ignored.
- Outputs `go`, `load_*`, `sol_rst` are registered and glitch-free.
- The A index counter is at least 16 bits wide, with no wrap for N≤MAX_N.
- Buffers and the X array are not cleared by reset; their contents after reset are undefined until written.

## Timing
- Reset values: `busy`=0, `done`=0, `fail_flag`=0, `timeout_flag`=0, `go`=0, `load_B`=0, `load_A`=0, `B_next`=0, `A_next`=0, `res_data`=0, `sol_rst`=1 (solver held in reset while `rst`=0).
- Reset mid-run: abort at the next edge with the values above. The run does not resume.
- `start` accepted in cycle t → `sol_rst` high in cycles t+1 and t+2.
- Load pulse period is 1+GAP cycles. Total load time is (N + N*N)*(1+GAP) cycles plus fixed overhead.
- Solver `drdy`/`dout` are registered, so the first `drdy`=1 cycle carries X[0]. Capture is N consecutive cycles with no gaps.
- `res_data` updates 1 cycle after `res_addr`. It is valid any time; it is stable-meaningful after `done`.
- `done` and a flag update land in the same cycle.

## Test plan
- **2×2 solve, real solver, GAP=2:**
  - Stimulus: A={1024,256,256,768}, B={256,512}, N=2, threshold=1, max_iter=100.
  - Required: `done` with both flags 0; X[0]=23±2, X[1]=163±2.
  - Also required: exactly 2 `load_B` and 4 `load_A` rising edges, each with the correct data held.
- **Non-dominant matrix:**
  - Stimulus: A={256,512,512,256}, B={256,256}.
  - Required: `done` with `fail_flag`=1 and `timeout_flag`=0.
- **Timeout:**
  - Stimulus: stub solver that never asserts `drdy`, TIMEOUT=100.
  - Required: `done` with `timeout_flag`=1 exactly 100 cycles after WAIT entry.
- **Bad size:**
  - Stimulus: `n_in`=0, and separately `n_in`=16.
  - Required: `done` within 2 cycles with `fail_flag`=1, and no pulse on `sol_rst`, `go` or `load_*`.
- **Busy protection:**
  - Stimulus: a second `start` and a `cfg_we` to B[0] during LDA.
  - Required: no restart, buffer unchanged, results identical to the 2×2 case.
- **Reset mid-LDA:**
  - Stimulus: `rst`=0 for 1 cycle during LDA.
  - Required: all outputs at reset values next cycle, `sol_rst`=1.
  - Then: a fresh `start` completes the 2×2 case correctly.

Source files
------------

// File: rtl/jacobi_feeder_if.sv
// Host-side register bus for jacobi_feeder: buffer writes, run control,
// status flags and the random-access result port.
interface jacobi_feeder_if #(
    parameter int W = 27
);
    logic         cfg_we;
    logic         cfg_sel;
    logic [7:0]   cfg_addr;
    logic [W-1:0] cfg_data;
    logic [7:0]   n_in;
    logic         start;
    logic         busy;
    logic         done;
    logic         fail_flag;
    logic         timeout_flag;
    logic [7:0]   res_addr;
    logic [W-1:0] res_data;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_data, n_in, start, res_addr,
        input  busy, done, fail_flag, timeout_flag, res_data
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_data, n_in, start, res_addr,
        output busy, done, fail_flag, timeout_flag, res_data
    );
endinterface

// File: rtl/jacobi_feeder.sv
// Host-side initiator for a jacobi_iter solver. Holds one A matrix and one
// B vector, sequences the solver reset/go/load protocol with paced strobes,
// captures the streamed X result and reports pass/fail/timeout to the host.
module jacobi_feeder #(
    parameter int W       = 27,
    parameter int MAX_N   = 15,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst,
    jacobi_feeder_if.slave host,
    output logic         sol_rst,
    output logic         go,
    output logic         load_B,
    output logic         load_A,
    output logic [W-1:0] B_next,
    output logic [W-1:0] A_next,
    input  logic         sol_drdy,
    input  logic [W-1:0] sol_dout,
    input  logic         sol_fail
);

    localparam int BW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
    localparam logic [7:0]  MAX_N8   = 8'(MAX_N);
    localparam logic [15:0] A_SIZE   = 16'(MAX_N * MAX_N);
    localparam logic [7:0]  GAP8     = 8'(GAP);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, SRST, GO, LDB, GAPB, LDA, WAIT, CAP, FIN
    } state_t;

    state_t       state, state_n;
    logic [7:0]   phase, phase_n;
    logic [15:0]  idx, idx_n;
    logic [31:0]  timer, timer_n;
    logic [7:0]   n_reg, n_n;
    logic         fail_r, fail_n;
    logic         tmo_r, tmo_n;
    logic         busy_r, busy_n;
    logic         done_r, done_n;
    logic         go_n, load_b_n, load_a_n, sol_rst_n;
    logic [W-1:0] b_next_n, a_next_n;
    logic [W-1:0] res_r;
    logic         x_we;
    logic [BW-1:0] x_widx;
    logic [15:0]  nn, last_b, last_a;

    logic [W-1:0] b_buf [MAX_N];
    logic [W-1:0] a_buf [MAX_N*MAX_N];
    logic [W-1:0] x_mem [MAX_N];

    assign nn     = {8'd0, n_reg} * {8'd0, n_reg};
    assign last_b = {8'd0, n_reg} - 16'd1;
    assign last_a = nn - 16'd1;

    assign host.busy         = busy_r;
    assign host.done         = done_r;
    assign host.fail_flag    = fail_r;
    assign host.timeout_flag = tmo_r;
    assign host.res_data     = res_r;

    // Next-state sequencing plus the next value of every registered output,
    // decoded from the next state so the strobes leave a flop cleanly.
    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        timer_n = timer;
        n_n     = n_reg;
        fail_n  = fail_r;
        tmo_n   = tmo_r;
        x_we    = 1'b0;
        x_widx  = '0;

        case (state)
            IDLE: begin
                if (host.start) begin
                    fail_n  = 1'b0;
                    tmo_n   = 1'b0;
                    phase_n = '0;
                    idx_n   = '0;
                    timer_n = '0;
                    if (host.n_in == 8'd0 || host.n_in > MAX_N8) begin
                        fail_n  = 1'b1;
                        state_n = FIN;
                    end else begin
                        n_n     = host.n_in;
                        state_n = SRST;
                    end
                end
            end
            SRST: begin
                if (phase == 8'd2) begin
                    phase_n = '0;
                    state_n = GO;
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            GO: begin
                if (phase == GAP8) begin
                    phase_n = '0;
                    idx_n   = '0;
                    state_n = LDB;
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            LDB: begin
                if (phase == GAP8) begin
                    phase_n = '0;
                    if (idx == last_b) begin
                        idx_n   = '0;
                        state_n = GAPB;
                    end else begin
                        idx_n = idx + 16'd1;
                    end
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            GAPB: begin
                if (phase == 8'd1) begin
                    phase_n = '0;
                    idx_n   = '0;
                    state_n = LDA;
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            LDA: begin
                if (phase == GAP8) begin
                    phase_n = '0;
                    if (idx == last_a) begin
                        idx_n   = '0;
                        timer_n = '0;
                        state_n = WAIT;
                    end else begin
                        idx_n = idx + 16'd1;
                    end
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            WAIT: begin
                if (sol_drdy) begin
                    if (sol_fail) begin
                        fail_n  = 1'b1;
                        state_n = FIN;
                    end else begin
                        x_we    = 1'b1;
                        x_widx  = '0;
                        idx_n   = 16'd1;
                        state_n = (n_reg == 8'd1) ? FIN : CAP;
                    end
                end else if (timer == TMO_LAST) begin
                    tmo_n   = 1'b1;
                    state_n = FIN;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            CAP: begin
                x_we   = 1'b1;
                x_widx = idx[BW-1:0];
                if (idx == last_b) begin
                    state_n = FIN;
                end else begin
                    idx_n = idx + 16'd1;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n    = (state_n != IDLE);
        done_n    = (state_n == FIN);
        go_n      = (state_n == GO)  && (phase_n == 8'd0);
        load_b_n  = (state_n == LDB) && (phase_n == 8'd0);
        load_a_n  = (state_n == LDA) && (phase_n == 8'd0);
        sol_rst_n = (state_n == SRST) ? (phase_n < 8'd2) : sol_rst;
        b_next_n  = (state_n == LDB) ? b_buf[idx_n[BW-1:0]] : B_next;
        a_next_n  = (state_n == LDA) ? a_buf[idx_n[AW-1:0]] : A_next;
    end

    // State, counters and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            phase   <= '0;
            idx     <= '0;
            timer   <= '0;
            n_reg   <= '0;
            fail_r  <= 1'b0;
            tmo_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            go      <= 1'b0;
            load_B  <= 1'b0;
            load_A  <= 1'b0;
            sol_rst <= 1'b1;
            B_next  <= '0;
            A_next  <= '0;
            res_r   <= '0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            idx     <= idx_n;
            timer   <= timer_n;
            n_reg   <= n_n;
            fail_r  <= fail_n;
            tmo_r   <= tmo_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            go      <= go_n;
            load_B  <= load_b_n;
            load_A  <= load_a_n;
            sol_rst <= sol_rst_n;
            B_next  <= b_next_n;
            A_next  <= a_next_n;
            res_r   <= (host.res_addr < MAX_N8) ? x_mem[host.res_addr[BW-1:0]] : '0;
        end
    end

    // Buffer and result storage; never cleared, host writes only while idle.
    always_ff @(posedge clk) begin
        if (rst && state == IDLE && host.cfg_we) begin
            if (!host.cfg_sel) begin
                if (host.cfg_addr < MAX_N8) begin
                    b_buf[host.cfg_addr[BW-1:0]] <= host.cfg_data;
                end
            end else if ({8'd0, host.cfg_addr} < A_SIZE) begin
                a_buf[host.cfg_addr[AW-1:0]] <= host.cfg_data;
            end
        end
        if (rst && x_we) begin
            x_mem[x_widx] <= sol_dout;
        end
    end

endmodule

// File: tb/tb_jacobi_feeder.sv
// Self-checking bench for jacobi_feeder: a solver stub answers the load
// protocol, a queue-based model predicts loads, flags, timing and results.
module tb_jacobi_feeder;

    localparam int W     = 27;
    localparam int MAX_N = 15;
    localparam int GAP   = 2;
    localparam int TMO   = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sol_rst, go, load_B, load_A;
    logic [W-1:0] B_next, A_next;
    logic         sol_drdy = 1'b0;
    logic         sol_fail = 1'b0;
    logic [W-1:0] sol_dout = '0;

    int n_checks = 0;
    int n_fail   = 0;

    jacobi_feeder_if #(.W(W)) hif();

    jacobi_feeder #(.W(W), .MAX_N(MAX_N), .GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .host(hif.slave),
        .sol_rst(sol_rst), .go(go), .load_B(load_B), .load_A(load_A),
        .B_next(B_next), .A_next(A_next),
        .sol_drdy(sol_drdy), .sol_dout(sol_dout), .sol_fail(sol_fail)
    );

    always #5 clk = ~clk;

    // Reference data for the current case and what the solver side observed.
    logic [W-1:0] a_mat [$];
    logic [W-1:0] b_vec [$];
    logic [W-1:0] x_exp [$];
    logic [W-1:0] qb [$];
    logic [W-1:0] qa [$];
    int cyc = 0;
    int go_cnt = 0;
    int hold_err = 0;
    int last_a_cyc = 0;
    int b_age = GAP;
    int a_age = GAP;
    logic [W-1:0] last_b = '0;
    logic [W-1:0] last_a = '0;

    // Free-running cycle count used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Solver-side monitor: records each load strobe and checks data is held
    // through the low cycles that follow it.
    always @(negedge clk) begin
        if (load_B) begin
            qb.push_back(B_next);
            last_b = B_next;
            b_age = 0;
        end else if (b_age < GAP) begin
            b_age++;
            if (B_next !== last_b) hold_err++;
        end
        if (load_A) begin
            qa.push_back(A_next);
            last_a = A_next;
            a_age = 0;
            last_a_cyc = cyc;
        end else if (a_age < GAP) begin
            a_age++;
            if (A_next !== last_a) hold_err++;
        end
        if (go) go_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int absW(input logic [W-1:0] v);
        int x;
        x = int'($signed(v));
        return (x < 0) ? -x : x;
    endfunction

    // Strict row diagonal dominance of an n x n row-major matrix.
    function automatic bit dominant(input logic [W-1:0] m [$], input int n);
        for (int i = 0; i < n; i++) begin
            int d, s;
            s = 0;
            d = absW(m[i*n+i]);
            for (int j = 0; j < n; j++) if (j != i) s += absW(m[i*n+j]);
            if (d <= s) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cfgWrite(input logic sel, input int addr, input logic [W-1:0] data);
        @(negedge clk);
        hif.cfg_we   = 1'b1;
        hif.cfg_sel  = sel;
        hif.cfg_addr = 8'(addr);
        hif.cfg_data = data;
        @(negedge clk);
        hif.cfg_we   = 1'b0;
    endtask

    task automatic writeBuffers(input int n);
        for (int k = 0; k < n; k++) cfgWrite(1'b0, k, b_vec[k]);
        for (int k = 0; k < n*n; k++) cfgWrite(1'b1, k, a_mat[k]);
    endtask

    task automatic genCase(input int n, input bit dom);
        int s, v;
        a_mat.delete(); b_vec.delete(); x_exp.delete();
        for (int k = 0; k < n*n; k++) a_mat.push_back('0);
        for (int i = 0; i < n; i++) begin
            s = 0;
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    v = int'($urandom_range(0, 400)) - 200;
                    a_mat[i*n+j] = W'(v);
                    s += (v < 0) ? -v : v;
                end
            end
            a_mat[i*n+i] = dom ? W'(s + 1 + int'($urandom_range(0, 500))) : W'(s / 2);
            b_vec.push_back(W'($urandom));
            x_exp.push_back(W'($urandom));
        end
    endtask

    task automatic set2x2();
        a_mat = '{27'd1024, 27'd256, 27'd256, 27'd768};
        b_vec = '{27'd256, 27'd512};
        x_exp = '{27'd23, 27'd163};
    endtask

    // One full run of size n. no_drdy leaves the solver silent; poke fires a
    // stray start and buffer write while the A matrix is being loaded.
    task automatic applyStimulus(input int n, input bit no_drdy, input bit poke);
        bit exp_fail, stub_fail, poked;
        int done_cyc;
        exp_fail = !no_drdy && !dominant(a_mat, n);
        poked = 1'b0;
        @(posedge clk); #1;
        qb.delete(); qa.delete(); go_cnt = 0; hold_err = 0;
        @(negedge clk);
        hif.n_in  = 8'(n);
        hif.start = 1'b1;
        @(posedge clk); #1;
        hif.start = 1'b0;
        @(negedge clk);
        checkOutput("srst_t1", sol_rst, 1);
        checkOutput("busy_run", hif.busy, 1);
        @(negedge clk);
        checkOutput("srst_t2", sol_rst, 1);
        @(negedge clk);
        checkOutput("srst_t3", sol_rst, 0);
        for (int k = 0; k < 4000 && qa.size() < n*n; k++) begin
            @(negedge clk);
            hif.start  = 1'b0;
            hif.cfg_we = 1'b0;
            if (poke && !poked && qa.size() >= 1) begin
                poked        = 1'b1;
                hif.n_in     = 8'd3;
                hif.start    = 1'b1;
                hif.cfg_we   = 1'b1;
                hif.cfg_sel  = 1'b0;
                hif.cfg_addr = 8'd0;
                hif.cfg_data = ~b_vec[0];
            end
        end
        hif.start  = 1'b0;
        hif.cfg_we = 1'b0;
        checkOutput("lda_count", qa.size(), n*n);
        if (!no_drdy) begin
            repeat ($urandom_range(3, 20)) @(negedge clk);
            stub_fail = !dominant(qa, n);
            if (stub_fail) begin
                sol_drdy = 1'b1;
                sol_fail = 1'b1;
                @(negedge clk);
            end else begin
                for (int k = 0; k < n; k++) begin
                    sol_drdy = 1'b1;
                    sol_dout = x_exp[k];
                    @(negedge clk);
                end
            end
            sol_drdy = 1'b0;
            sol_fail = 1'b0;
        end
        for (int k = 0; k < 400 && !hif.done; k++) @(negedge clk);
        done_cyc = cyc;
        checkOutput("done_seen", hif.done, 1);
        checkOutput("fail_flag", hif.fail_flag, exp_fail);
        checkOutput("timeout_flag", hif.timeout_flag, no_drdy);
        if (no_drdy) checkOutput("tmo_latency", done_cyc - last_a_cyc, GAP + 1 + TMO);
        @(negedge clk);
        checkOutput("done_pulse", hif.done, 0);
        checkOutput("busy_end", hif.busy, 0);
        checkOutput("fail_sticky", hif.fail_flag, exp_fail);
        checkOutput("ldb_count", qb.size(), n);
        checkOutput("go_count", go_cnt, 1);
        checkOutput("data_hold", hold_err, 0);
        for (int k = 0; k < n; k++)
            checkOutput($sformatf("B_data[%0d]", k), (k < qb.size()) ? qb[k] : ~b_vec[k], b_vec[k]);
        for (int k = 0; k < n*n; k++)
            checkOutput($sformatf("A_data[%0d]", k), (k < qa.size()) ? qa[k] : ~a_mat[k], a_mat[k]);
        if (!no_drdy && !exp_fail) begin
            for (int k = 0; k < n; k++) begin
                hif.res_addr = 8'(k);
                @(negedge clk);
                checkOutput($sformatf("X[%0d]", k), hif.res_data, x_exp[k]);
            end
        end
    endtask

    task automatic badSize(input int n);
        logic srst_before;
        @(posedge clk); #1;
        qb.delete(); qa.delete(); go_cnt = 0;
        srst_before = sol_rst;
        @(negedge clk);
        hif.n_in  = 8'(n);
        hif.start = 1'b1;
        @(posedge clk); #1;
        hif.start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 1 && !hif.done; k++) @(negedge clk);
        checkOutput("bad_done", hif.done, 1);
        checkOutput("bad_fail", hif.fail_flag, 1);
        checkOutput("bad_tmo", hif.timeout_flag, 0);
        checkOutput("bad_srst", sol_rst, srst_before);
        @(negedge clk);
        checkOutput("bad_idle", hif.busy, 0);
        checkOutput("bad_go", go_cnt, 0);
        checkOutput("bad_loads", qb.size() + qa.size(), 0);
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_busy"}, hif.busy, 0);
        checkOutput({pfx, "_done"}, hif.done, 0);
        checkOutput({pfx, "_fail"}, hif.fail_flag, 0);
        checkOutput({pfx, "_tmo"}, hif.timeout_flag, 0);
        checkOutput({pfx, "_go"}, go, 0);
        checkOutput({pfx, "_loadB"}, load_B, 0);
        checkOutput({pfx, "_loadA"}, load_A, 0);
        checkOutput({pfx, "_Bnext"}, B_next, 0);
        checkOutput({pfx, "_Anext"}, A_next, 0);
        checkOutput({pfx, "_res"}, hif.res_data, 0);
        checkOutput({pfx, "_solrst"}, sol_rst, 1);
    endtask

    initial begin
        hif.cfg_we   = 1'b0;
        hif.cfg_sel  = 1'b0;
        hif.cfg_addr = '0;
        hif.cfg_data = '0;
        hif.n_in     = '0;
        hif.start    = 1'b0;
        hif.res_addr = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] 2x2 dominant solve");
        set2x2();
        writeBuffers(2);
        applyStimulus(2, 1'b0, 1'b0);

        $display("[TB] non-dominant matrix");
        a_mat = '{27'd256, 27'd512, 27'd512, 27'd256};
        b_vec = '{27'd256, 27'd256};
        x_exp = '{27'd0, 27'd0};
        writeBuffers(2);
        applyStimulus(2, 1'b0, 1'b0);

        $display("[TB] timeout");
        set2x2();
        writeBuffers(2);
        applyStimulus(2, 1'b1, 1'b0);

        $display("[TB] bad sizes");
        badSize(0);
        badSize(MAX_N + 1);

        $display("[TB] busy protection");
        applyStimulus(2, 1'b0, 1'b1);
        applyStimulus(2, 1'b0, 1'b0);

        $display("[TB] reset during A load");
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        @(negedge clk);
        hif.n_in  = 8'd2;
        hif.start = 1'b1;
        @(posedge clk); #1;
        hif.start = 1'b0;
        for (int k = 0; k < 200 && qa.size() < 2; k++) @(negedge clk);
        checkOutput("reach_lda", qa.size(), 2);
        rst = 1'b0;
        @(posedge clk); #1;
        checkResetValues("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(2, 1'b0, 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 5));
            genCase(n, $urandom_range(0, 3) != 0);
            writeBuffers(n);
            applyStimulus(n, 1'b0, 1'b0);
        end
        genCase(1, 1'b1);
        writeBuffers(1);
        applyStimulus(1, 1'b0, 1'b0);
        genCase(MAX_N, 1'b1);
        writeBuffers(MAX_N);
        applyStimulus(MAX_N, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
